// File: rtl/interrupt_controller.sv
// interrupt_controller: arbitrates masked timer interrupt flags at an
// instruction boundary, pushes the return PC (low byte, then high byte)
// through a req/ack stack port, redirects the program counter to the
// ATmega32A vector and pulses flag-clear / SREG-I-clear for one cycle.
//
// Handshake: push_req is held high with push_data stable until an edge at
// which push_ack=1; that edge transfers the byte. push_ack seen outside a
// push state is ignored.
//
// Optional build macro INTERRUPT_EXT_EN adds external level interrupts
// int0/int1 (above all timer sources) and their int_clear pulse outputs.
module interrupt_controller #(
  parameter int PC_WIDTH = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          tifr,
  input  logic [7:0]          timsk,
  input  logic                i_flag,
  input  logic                instr_boundary,
  input  logic [PC_WIDTH-1:0] program_counter,
  input  logic                push_ack,
`ifdef INTERRUPT_EXT_EN
  input  logic                int0,
  input  logic                int1,
  output logic [1:0]          int_clear,
`endif
  output logic                push_req,
  output logic [7:0]          push_data,
  output logic                hold,
  output logic                PC_overwrite,
  output logic [PC_WIDTH-1:0] PC_new,
  output logic [7:0]          tifr_clear,
  output logic                clear_i,
  output logic                irq_pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PUSH_LO = 2'd1,
    PUSH_HI = 2'd2,
    JUMP    = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [7:0]          masked;
  logic                any_req;
  logic                take;
  logic [PC_WIDTH-1:0] vec_d;
  logic [7:0]          tclr_d;
  logic [PC_WIDTH-1:0] vec_q;
  logic [7:0]          tclr_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         pc_ext;
  logic                guard;
`ifdef INTERRUPT_EXT_EN
  logic [1:0]          iclr_d;
  logic [1:0]          iclr_q;
`endif

  // Priority encode the pending sources; ascending scan so the highest bit wins.
  always_comb begin
    masked  = tifr & timsk;
    any_req = |masked;
    vec_d   = '0;
    tclr_d  = '0;
    for (int i = 0; i < 8; i++) begin
      if (masked[i]) begin
        vec_d  = PC_WIDTH'(8 + 2 * (7 - i));
        tclr_d = 8'b1 << i;
      end
    end
`ifdef INTERRUPT_EXT_EN
    iclr_d  = '0;
    any_req = any_req | int0 | int1;
    if (int1) begin
      vec_d  = PC_WIDTH'(4);
      tclr_d = '0;
      iclr_d = 2'b10;
    end
    if (int0) begin
      vec_d  = PC_WIDTH'(2);
      tclr_d = '0;
      iclr_d = 2'b01;
    end
`endif
  end

  // Next-state logic; service is only taken from IDLE outside the guard cycle.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (instr_boundary && i_flag && any_req && !guard) begin
          take       = 1'b1;
          state_next = PUSH_LO;
        end
      end
      PUSH_LO: if (push_ack) state_next = PUSH_HI;
      PUSH_HI: if (push_ack) state_next = JUMP;
      JUMP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, latched service context, guard and pending flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      vec_q       <= '0;
      tclr_q      <= '0;
      pc_q        <= '0;
      guard       <= 1'b0;
      irq_pending <= 1'b0;
`ifdef INTERRUPT_EXT_EN
      iclr_q      <= '0;
`endif
    end else begin
      state       <= state_next;
      guard       <= (state == JUMP);
      irq_pending <= |masked;
      if (take) begin
        vec_q  <= vec_d;
        tclr_q <= tclr_d;
        pc_q   <= program_counter;
`ifdef INTERRUPT_EXT_EN
        iclr_q <= iclr_d;
`endif
      end
    end
  end

  assign pc_ext = 16'(pc_q);

  // Moore outputs decoded from the state register only.
  always_comb begin
    push_req     = 1'b0;
    push_data    = '0;
    hold         = (state != IDLE);
    PC_overwrite = 1'b0;
    PC_new       = '0;
    tifr_clear   = '0;
    clear_i      = 1'b0;
`ifdef INTERRUPT_EXT_EN
    int_clear    = '0;
`endif
    case (state)
      PUSH_LO: begin
        push_req  = 1'b1;
        push_data = pc_ext[7:0];
      end
      PUSH_HI: begin
        push_req  = 1'b1;
        push_data = pc_ext[15:8];
      end
      JUMP: begin
        PC_overwrite = 1'b1;
        PC_new       = vec_q;
        tifr_clear   = tclr_q;
        clear_i      = 1'b1;
`ifdef INTERRUPT_EXT_EN
        int_clear    = iclr_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: single service, priority and
// guard, disabled I flag, stalled push, reset mid-push, optional ext ints.
module tb_interrupt_controller;

  logic        clk;
  logic        reset;
  logic [7:0]  tifr;
  logic [7:0]  timsk;
  logic        i_flag;
  logic        instr_boundary;
  logic [13:0] program_counter;
  logic        push_ack;
  logic        push_req;
  logic [7:0]  push_data;
  logic        hold;
  logic        PC_overwrite;
  logic [13:0] PC_new;
  logic [7:0]  tifr_clear;
  logic        clear_i;
  logic        irq_pending;
`ifdef INTERRUPT_EXT_EN
  logic        int0;
  logic        int1;
  logic [1:0]  int_clear;
`endif

  int total = 0;
  int bad   = 0;

  interrupt_controller #(.PC_WIDTH(14)) dut (
    .clk             (clk),
    .reset           (reset),
    .tifr            (tifr),
    .timsk           (timsk),
    .i_flag          (i_flag),
    .instr_boundary  (instr_boundary),
    .program_counter (program_counter),
    .push_ack        (push_ack),
`ifdef INTERRUPT_EXT_EN
    .int0            (int0),
    .int1            (int1),
    .int_clear       (int_clear),
`endif
    .push_req        (push_req),
    .push_data       (push_data),
    .hold            (hold),
    .PC_overwrite    (PC_overwrite),
    .PC_new          (PC_new),
    .tifr_clear      (tifr_clear),
    .clear_i         (clear_i),
    .irq_pending     (irq_pending)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Walks one full service with push_ack=1; called at a negedge with the
  // trigger conditions already applied. Models the timer clearing its flag.
  task automatic service(input string t, input logic [13:0] pc,
                         input logic [13:0] vec, input logic [7:0] tclr,
                         input logic [1:0] iclr);
    @(negedge clk);
    chk({t, "_lo_req"},  push_req, 1);
    chk({t, "_lo_data"}, push_data, pc[7:0]);
    chk({t, "_lo_hold"}, hold, 1);
    chk({t, "_lo_ovr"},  PC_overwrite, 0);
    chk({t, "_pend"},    irq_pending, 1);
    @(negedge clk);
    chk({t, "_hi_req"},  push_req, 1);
    chk({t, "_hi_data"}, push_data, {2'b00, pc[13:8]});
    chk({t, "_hi_hold"}, hold, 1);
    @(negedge clk);
    chk({t, "_j_ovr"},   PC_overwrite, 1);
    chk({t, "_j_vec"},   PC_new, vec);
    chk({t, "_j_tclr"},  tifr_clear, tclr);
    chk({t, "_j_clri"},  clear_i, 1);
    chk({t, "_j_req"},   push_req, 0);
    chk({t, "_j_hold"},  hold, 1);
`ifdef INTERRUPT_EXT_EN
    chk({t, "_j_iclr"},  int_clear, iclr);
    if (iclr[0]) int0 = 1'b0;
    if (iclr[1]) int1 = 1'b0;
`else
    if (iclr != 2'b00) chk({t, "_iclr_unused"}, iclr, 0);
`endif
    tifr = tifr & ~tclr;
    @(negedge clk);
    chk({t, "_i_hold"},  hold, 0);
    chk({t, "_i_ovr"},   PC_overwrite, 0);
    chk({t, "_i_tclr"},  tifr_clear, 0);
    chk({t, "_i_clri"},  clear_i, 0);
  endtask

  initial begin
    reset           = 1'b1;
    tifr            = 8'h00;
    timsk           = 8'h00;
    i_flag          = 1'b0;
    instr_boundary  = 1'b0;
    program_counter = 14'h0000;
    push_ack        = 1'b0;
`ifdef INTERRUPT_EXT_EN
    int0 = 1'b0;
    int1 = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req",  push_req, 0);
    chk("rst_hold", hold, 0);
    chk("rst_ovr",  PC_overwrite, 0);
    chk("rst_pcn",  PC_new, 0);
    chk("rst_pend", irq_pending, 0);
    reset = 1'b0;

    // Single TOV0 service
    @(negedge clk);
    tifr = 8'h01; timsk = 8'h01; i_flag = 1'b1; push_ack = 1'b1;
    program_counter = 14'h0123; instr_boundary = 1'b1;
    service("t1", 14'h0123, 14'h016, 8'h01, 2'b00);
    instr_boundary = 1'b0;
    @(negedge clk);
    chk("t1_pend_clr", irq_pending, 0);

    // Priority TOV1 over TOV0, then guard cycle, then TOV0
    tifr = 8'h05; timsk = 8'hFF; program_counter = 14'h0200; instr_boundary = 1'b1;
    service("t2a", 14'h0200, 14'h012, 8'h04, 2'b00);
    @(negedge clk);
    chk("t2_guard_req", push_req, 0);
    service("t2b", 14'h0200, 14'h016, 8'h01, 2'b00);
    instr_boundary = 1'b0;

    // Global interrupt disable
    i_flag = 1'b0; tifr = 8'h00; timsk = 8'h80;
    @(negedge clk);
    chk("t3_pend0", irq_pending, 0);
    tifr = 8'h80;
    @(negedge clk);
    chk("t3_pend1", irq_pending, 1);
    instr_boundary = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_req", push_req, 0);
      chk("t3_ovr", PC_overwrite, 0);
    end

    // Withheld ack in PUSH_LO, then reset during PUSH_HI
    i_flag = 1'b1; push_ack = 1'b0; program_counter = 14'h2ABC;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      instr_boundary = 1'b0;
      program_counter = 14'h1111;
      chk("t4_req",  push_req, 1);
      chk("t4_data", push_data, 8'hBC);
      chk("t4_hold", hold, 1);
    end
    push_ack = 1'b1;
    @(negedge clk);
    push_ack = 1'b0;
    chk("t4_hi_data", push_data, 8'h2A);
    @(negedge clk);
    chk("t4_hi_stay", push_req, 1);
    chk("t4_hi_ovr",  PC_overwrite, 0);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_req",  push_req, 0);
    chk("t5_rst_hold", hold, 0);
    chk("t5_rst_data", push_data, 0);
    chk("t5_rst_pend", irq_pending, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_idle_hold", hold, 0);
    push_ack = 1'b1; program_counter = 14'h0345; instr_boundary = 1'b1;
    service("t5", 14'h0345, 14'h008, 8'h80, 2'b00);
    instr_boundary = 1'b0;

`ifdef INTERRUPT_EXT_EN
    // External int0 beats OCF2
    @(negedge clk);
    tifr = 8'h80; timsk = 8'h80; int0 = 1'b1;
    program_counter = 14'h0777; instr_boundary = 1'b1;
    service("ext", 14'h0777, 14'h002, 8'h00, 2'b01);
    instr_boundary = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
